tdes_pass_sequencer: RTL and testbench

TDES_PASS_SEQUENCER -- requirements
Module: tdes_pass_sequencer

---
 rtl/tdes_pass_sequencer.sv | 136 +++++++++++++
 tb/tb_tdes_pass_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdes_pass_sequencer.sv
// rtl/tdes_pass_sequencer.sv - three-pass Triple DES sequencer around a single-DES core
module tdes_pass_sequencer #(
    parameter int TIMEOUT = 32
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        start,
    input  logic        encryption_type,
    input  logic [63:0] data_in,
    input  logic [63:0] key1,
    input  logic [63:0] key2,
    input  logic [63:0] key3,
    output logic        des_start,
    output logic        des_decrypt,
    output logic [63:0] des_key,
    output logic [63:0] des_data,
    input  logic        des_done,
    input  logic [63:0] des_result,
    output logic        busy,
    output logic        result_valid,
    output logic [63:0] result,
    input  logic        result_ack,
    output logic [1:0]  pass,
    output logic        error,
    input  logic        err_clear
);

    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        WAIT   = 3'd2,
        DONE   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    state_t          state;
    logic [WD_W-1:0] wdog;
    logic [63:0]     work;
    logic [63:0]     k1;
    logic [63:0]     k2;
    logic [63:0]     k3;
    logic            decrypt_op;

    assign des_data = work;

    // Decrypt runs the encrypt schedule backwards; the middle pass always inverts the mode.
    always_comb begin
        des_key     = k2;
        des_decrypt = decrypt_op ^ (pass == 2'd1);
        case (pass)
            2'd0:    des_key = decrypt_op ? k3 : k1;
            2'd2:    des_key = decrypt_op ? k1 : k3;
            default: des_key = k2;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= IDLE;
            wdog         <= '0;
            work         <= '0;
            k1           <= '0;
            k2           <= '0;
            k3           <= '0;
            decrypt_op   <= 1'b0;
            pass         <= 2'd0;
            des_start    <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            error        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        work       <= data_in;
                        k1         <= key1;
                        k2         <= key2;
                        k3         <= key3;
                        decrypt_op <= encryption_type;
                        pass       <= 2'd0;
                        des_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    des_start <= 1'b0;
                    wdog      <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion on the watchdog's final cycle still counts as success.
                    if (des_done) begin
                        work <= des_result;
                        if (pass == 2'd2) begin
                            result_valid <= 1'b1;
                            result       <= des_result;
                            state        <= DONE;
                        end else begin
                            pass      <= pass + 2'd1;
                            des_start <= 1'b1;
                            state     <= LAUNCH;
                        end
                    end else if (wdog == WD_LAST) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        result_valid <= 1'b0;
                        result       <= '0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                ERROR: begin
                    if (err_clear) begin
                        error <= 1'b0;
                        busy  <= 1'b0;
                        pass  <= 2'd0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdes_pass_sequencer.sv
// tb/tb_tdes_pass_sequencer.sv - scoreboard bench for tdes_pass_sequencer with a behavioural core
module tb_tdes_pass_sequencer;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        start;
    logic        encryption_type;
    logic [63:0] data_in;
    logic [63:0] key1;
    logic [63:0] key2;
    logic [63:0] key3;
    logic        des_start;
    logic        des_decrypt;
    logic [63:0] des_key;
    logic [63:0] des_data;
    logic        des_done;
    logic [63:0] des_result;
    logic        busy;
    logic        result_valid;
    logic [63:0] result;
    logic        result_ack;
    logic [1:0]  pass;
    logic        error;
    logic        err_clear;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [63:0] key;
        logic        dec;
        logic [63:0] data;
        logic [1:0]  pidx;
    } pass_t;

    pass_t       pass_q[$];
    logic [63:0] res_q[$];

    tdes_pass_sequencer #(.TIMEOUT(32)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .start(start), .encryption_type(encryption_type),
        .data_in(data_in), .key1(key1), .key2(key2), .key3(key3),
        .des_start(des_start), .des_decrypt(des_decrypt), .des_key(des_key), .des_data(des_data),
        .des_done(des_done), .des_result(des_result), .busy(busy), .result_valid(result_valid),
        .result(result), .result_ack(result_ack), .pass(pass), .error(error), .err_clear(err_clear)
    );

    always #5 HCLK = ~HCLK;

    // Stand-in for a DES core: cheap, key- and mode-dependent, and not self-inverse.
    function automatic logic [63:0] core_f(input logic [63:0] d, input logic [63:0] k, input logic dec);
        return {d[62:0], d[63]} ^ k ^ (dec ? 64'hFFFF_0000_FFFF_0000 : 64'h0);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_ctl"}, {58'd0, des_start, busy, result_valid, error, des_decrypt, pass}, 64'd0);
        chk({tag, "_bus"}, des_key | des_data | result, 64'd0);
    endtask

    task automatic do_op(input logic typ, input logic [63:0] d, input int n,
                         input int hold, input bit poke_start);
        logic [63:0] ks[3];
        logic [63:0] dd;
        logic [63:0] exp_res;
        logic [63:0] cd, ck;
        logic        cdec;
        pass_t       p;
        int          edges, cnt;
        bit          got;
        ks[0] = typ ? key3 : key1;
        ks[1] = key2;
        ks[2] = typ ? key1 : key3;
        dd = d;
        for (int i = 0; i < 3; i++) begin
            pass_q.push_back('{key: ks[i], dec: typ ^ (i == 1), data: dd, pidx: 2'(i)});
            dd = core_f(dd, ks[i], typ ^ (i == 1));
        end
        res_q.push_back(dd);
        exp_res = 64'd0;
        cd = 64'd0; ck = 64'd0; cdec = 1'b0;
        start = 1'b1; encryption_type = typ; data_in = d;
        @(negedge HCLK);
        start = 1'b0; encryption_type = ~typ; data_in = ~d;
        edges = 0; cnt = 0; got = 0;
        while (!got && edges < 400) begin
            des_done = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    des_done   = 1'b1;
                    des_result = core_f(cd, ck, cdec);
                end
            end
            if (des_start) begin
                if (pass_q.size() == 0) begin
                    chk("unexpected_des_start", 64'd1, 64'd0);
                end else begin
                    p = pass_q.pop_front();
                    chk("des_key", des_key, p.key);
                    chk("des_decrypt", {63'd0, des_decrypt}, {63'd0, p.dec});
                    chk("des_data", des_data, p.data);
                    chk("pass", {62'd0, pass}, {62'd0, p.pidx});
                end
                cd = des_data; ck = des_key; cdec = des_decrypt; cnt = n;
            end
            start = poke_start && (edges == 2);
            if (result_valid) begin
                got = 1;
                chk("latency", 64'(edges), 64'(3 * (n + 1)));
                exp_res = res_q.pop_front();
                chk("result", result, exp_res);
                chk("busy_done", {63'd0, busy}, 64'd1);
            end else begin
                @(negedge HCLK);
                edges++;
            end
        end
        start = 1'b0;
        des_done = 1'b0;
        chk("op_completed", {63'd0, got}, 64'd1);
        for (int h = 0; h < hold; h++) begin
            @(negedge HCLK);
            chk("hold_result", result, exp_res);
            chk("hold_valid", {62'd0, result_valid, des_start}, 64'd2);
        end
        result_ack = 1'b1;
        @(negedge HCLK);
        result_ack = 1'b0;
        chk("idle_after_ack", {61'd0, busy, result_valid, error}, 64'd0);
        chk("result_zero_idle", result, 64'd0);
        chk("pass_q_drained", 64'(pass_q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int  k;
        int  seen;
        bit  pend;
        HRESET = 1'b1; start = 1'b0; encryption_type = 1'b0; data_in = 64'd0;
        key1 = 64'h0123456789ABCDEF; key2 = 64'h23456789ABCDEF01; key3 = 64'h456789ABCDEF0123;
        des_done = 1'b0; des_result = 64'd0; result_ack = 1'b0; err_clear = 1'b0;
        repeat (2) @(negedge HCLK);
        chk_quiet("reset_state");
        HRESET = 1'b0;
        @(negedge HCLK);

        do_op(1'b0, 64'h4E6F772069732074, 1, 0, 0);
        do_op(1'b1, 64'h4E6F772069732074, 1, 0, 0);
        do_op(1'b0, 64'hDEADBEEF00C0FFEE, 3, 10, 1);
        do_op(1'b1, 64'h0F1E2D3C4B5A6978, 2, 0, 0);

        // Core never answers: watchdog trips after 32 WAIT cycles.
        start = 1'b1; encryption_type = 1'b0; data_in = 64'h1111;
        @(negedge HCLK);
        start = 1'b0;
        chk("to_launch", {63'd0, des_start}, 64'd1);
        k = 0;
        while (!error && k < 100) begin
            @(negedge HCLK);
            k++;
        end
        chk("timeout_cycles", 64'(k), 64'd33);
        chk("timeout_flags", {61'd0, busy, result_valid, error}, 64'b101);
        result_ack = 1'b1; start = 1'b1;
        @(negedge HCLK);
        result_ack = 1'b0; start = 1'b0;
        chk("error_sticky", {62'd0, error, busy}, 64'b11);
        err_clear = 1'b1;
        @(negedge HCLK);
        err_clear = 1'b0;
        chk("err_cleared", {61'd0, busy, error, des_start}, 64'd0);
        chk("err_pass", {62'd0, pass}, 64'd0);

        do_op(1'b0, 64'h0123012301230123, 32, 0, 0);

        // Reset while pass 1 waits; a late completion must not restart anything.
        start = 1'b1; encryption_type = 1'b1; data_in = 64'hCAFEF00DCAFEF00D;
        @(negedge HCLK);
        start = 1'b0;
        seen = 0; pend = 1'b0;
        for (int c = 0; c < 20; c++) begin
            des_done = pend;
            des_result = 64'h5555AAAA5555AAAA;
            pend = des_start;
            if (des_start) seen++;
            if (seen == 2) break;
            @(negedge HCLK);
        end
        des_done = 1'b0;
        chk("rst_reach_pass1", 64'(seen), 64'd2);
        chk("rst_pass_is_1", {62'd0, pass}, 64'd1);
        @(negedge HCLK);
        HRESET = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b0;
        des_done = 1'b1;
        chk_quiet("rst_mid");
        @(negedge HCLK);
        des_done = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk_quiet("rst_after");
            @(negedge HCLK);
        end
        do_op(1'b1, 64'h4E6F772069732074, 1, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
